// File: rtl/regfile_wr_pkg.sv
// Shared types and constants for the register-file write arbiter.
// A queued write is one wr_entry_t: target register, 64-bit data, byte mask.
package regfile_wr_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 64;
  localparam int REG_MASK_W = 8;
  localparam int NUM_REGS   = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
    logic [REG_MASK_W-1:0] mask;
  } wr_entry_t;

  localparam int ENTRY_W = $bits(wr_entry_t);

  // One-hot register select, used for conflict tracking and the busy vector.
  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] r;
    r    = '0;
    r[a] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/regfile_wr_fifo.sv
// Per-source write FIFO. Shift-register organisation: slot 0 is always the
// head, so the head, empty and not-full outputs all come straight from flops.
// A push is honoured only when the registered not-full flag was already set,
// so a pop on a full FIFO frees the slot for the following cycle.
module regfile_wr_fifo
  import regfile_wr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [ENTRY_W-1:0]       din_i,
  input  logic                     pop_i,
  output logic                     not_full_o,
  output logic                     empty_o,
  output logic [ENTRY_W-1:0]       head_o,
  output logic [DEPTH*ENTRY_W-1:0] entries_o,
  output logic [DEPTH-1:0]         valid_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d, base;
  logic               not_full_q, empty_q;

  // Next storage/occupancy: pop shifts toward the head, push lands after survivors.
  always_comb begin
    mem_d = mem_q;
    base  = count_q;
    if (pop_i && !empty_q) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      base = count_q - CNT_W'(1);
    end else begin
      base = count_q;
    end
    if (push_i && not_full_q) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = (base == CNT_W'(i)) ? din_i : mem_d[i];
      end
      count_d = base + CNT_W'(1);
    end else begin
      count_d = base;
    end
  end

  // Storage, occupancy and the registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q    <= '0;
      not_full_q <= 1'b1;
      empty_q    <= 1'b1;
    end else begin
      mem_q      <= mem_d;
      count_q    <= count_d;
      not_full_q <= (count_d != DEPTH_C);
      empty_q    <= (count_d == '0);
    end
  end

  // Expose every slot with its valid bit so the owner can build a busy vector.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_o[i*ENTRY_W +: ENTRY_W] = mem_q[i];
      valid_o[i]                      = (CNT_W'(i) < count_q);
    end
  end

  assign not_full_o = not_full_q;
  assign empty_o    = empty_q;
  assign head_o     = mem_q[0];

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-side front end for the 8x64 byte-masked register file.
// Buffers NUM_SRC producer streams, grants up to NUM_WPORTS heads per cycle
// round-robin (never two writers to the same register in a cycle) and
// exports a per-register busy vector for read-side stall logic.
// Optional: define REGFILE_WR_STATS_EN to add the saturating stall_cnt port.
module regfile_wr_arbiter
  import regfile_wr_pkg::*;
#(
  parameter int NUM_SRC    = 6,
  parameter int NUM_WPORTS = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SRC-1:0]               src_valid,
  output logic [NUM_SRC-1:0]               src_ready,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]    src_addr,
  input  logic [NUM_SRC*REG_DATA_W-1:0]    src_data,
  input  logic [NUM_SRC*REG_MASK_W-1:0]    src_mask,
  output logic [NUM_WPORTS-1:0]            wport_en,
  output logic [NUM_WPORTS*REG_ADDR_W-1:0] wport_addr,
  output logic [NUM_WPORTS*REG_DATA_W-1:0] wport_data,
  output logic [NUM_WPORTS*REG_MASK_W-1:0] wport_mask,
  output logic [NUM_REGS-1:0]              busy
`ifdef REGFILE_WR_STATS_EN
  ,
  output logic [31:0]                      stall_cnt
`endif
);

  localparam int PTR_W  = $clog2(NUM_SRC);
  localparam int PORT_W = $clog2(NUM_WPORTS + 1);
  localparam int PIDX_W = $clog2(NUM_WPORTS);

  logic [NUM_SRC-1:0]            fifo_empty;
  logic [NUM_SRC-1:0]            grant;
  logic [ENTRY_W-1:0]            fifo_head    [NUM_SRC];
  logic [FIFO_DEPTH*ENTRY_W-1:0] fifo_entries [NUM_SRC];
  logic [FIFO_DEPTH-1:0]         fifo_valid   [NUM_SRC];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_fifo
    regfile_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (src_valid[s] & src_ready[s]),
      .din_i      ({src_addr[s*REG_ADDR_W +: REG_ADDR_W],
                    src_data[s*REG_DATA_W +: REG_DATA_W],
                    src_mask[s*REG_MASK_W +: REG_MASK_W]}),
      .pop_i      (grant[s]),
      .not_full_o (src_ready[s]),
      .empty_o    (fifo_empty[s]),
      .head_o     (fifo_head[s]),
      .entries_o  (fifo_entries[s]),
      .valid_o    (fifo_valid[s])
    );
  end

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d, last_src, idx;
  logic [PTR_W:0]        sum;
  logic [PORT_W-1:0]     n_grant;
  logic [NUM_REGS-1:0]   taken;
  logic [NUM_WPORTS-1:0] port_vld;
  wr_entry_t             port_entry [NUM_WPORTS];
  wr_entry_t             cand;
  logic                  stall;

  // Round-robin scan from rr_ptr: grant heads while ports remain and the
  // target register is not already claimed this cycle; k-th grant -> port k.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    for (int j = 0; j < NUM_WPORTS; j++) begin
      port_entry[j] = '0;
    end
    taken    = '0;
    n_grant  = '0;
    last_src = rr_ptr_q;
    stall    = 1'b0;
    sum      = '0;
    idx      = '0;
    cand     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_SRC)) begin
        sum = sum - (PTR_W+1)'(NUM_SRC);
      end else begin
        sum = sum;
      end
      idx  = sum[PTR_W-1:0];
      cand = fifo_head[idx];
      if (!fifo_empty[idx]) begin
        if ((n_grant < PORT_W'(NUM_WPORTS)) && ((taken & addr_onehot(cand.addr)) == '0)) begin
          grant[idx]                     = 1'b1;
          port_vld[n_grant[PIDX_W-1:0]]  = 1'b1;
          port_entry[n_grant[PIDX_W-1:0]] = cand;
          taken                          = taken | addr_onehot(cand.addr);
          n_grant                        = n_grant + PORT_W'(1);
          last_src                       = idx;
        end else begin
          stall = 1'b1;
        end
      end else begin
        stall = stall;
      end
    end
    if (grant != '0) begin
      rr_ptr_d = (last_src == PTR_W'(NUM_SRC - 1)) ? '0 : last_src + PTR_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  logic [NUM_WPORTS-1:0] wport_en_q;
  wr_entry_t             wport_q [NUM_WPORTS];

  // Write-port registers: idle ports drop enable but keep their last payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wport_en_q <= '0;
      rr_ptr_q   <= '0;
      for (int j = 0; j < NUM_WPORTS; j++) begin
        wport_q[j] <= '0;
      end
    end else begin
      wport_en_q <= port_vld;
      rr_ptr_q   <= rr_ptr_d;
      for (int j = 0; j < NUM_WPORTS; j++) begin
        if (port_vld[j]) begin
          wport_q[j] <= port_entry[j];
        end
      end
    end
  end

  // Flatten the port registers onto the output buses.
  always_comb begin
    for (int j = 0; j < NUM_WPORTS; j++) begin
      wport_addr[j*REG_ADDR_W +: REG_ADDR_W] = wport_q[j].addr;
      wport_data[j*REG_DATA_W +: REG_DATA_W] = wport_q[j].data;
      wport_mask[j*REG_MASK_W +: REG_MASK_W] = wport_q[j].mask;
    end
  end
  assign wport_en = wport_en_q;

  wr_entry_t slot;

  // Busy: any queued entry or any enabled write port targeting the register.
  always_comb begin
    busy = '0;
    slot = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        slot = fifo_entries[s][e*ENTRY_W +: ENTRY_W];
        busy = busy | (fifo_valid[s][e] ? addr_onehot(slot.addr) : '0);
      end
    end
    for (int j = 0; j < NUM_WPORTS; j++) begin
      busy = busy | (wport_en_q[j] ? addr_onehot(wport_q[j].addr) : '0);
    end
  end

`ifdef REGFILE_WR_STATS_EN
  logic [31:0] stall_cnt_q;

  // Count cycles where some ready head was held back; saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0000_0000;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'h0000_0001;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic stats_unused;
  assign stats_unused = stall;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, single write, address
// conflict, port saturation and rotation, zero mask, backpressure and
// mid-flight reset. Build with REGFILE_WR_STATS_EN to include stall_cnt.
module tb_regfile_wr_arbiter;

  logic         clk;
  logic         rst_n;
  logic [5:0]   src_valid;
  logic [5:0]   src_ready;
  logic [17:0]  src_addr;
  logic [383:0] src_data;
  logic [47:0]  src_mask;
  logic [3:0]   wport_en;
  logic [11:0]  wport_addr;
  logic [255:0] wport_data;
  logic [31:0]  wport_mask;
  logic [7:0]   busy;
`ifdef REGFILE_WR_STATS_EN
  logic [31:0]  stall_cnt;
`endif

  int errors;
  int checks;

  regfile_wr_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .src_mask   (src_mask),
    .wport_en   (wport_en),
    .wport_addr (wport_addr),
    .wport_data (wport_data),
    .wport_mask (wport_mask),
    .busy       (busy)
`ifdef REGFILE_WR_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_src(input int i, input logic [2:0] a, input logic [63:0] d, input logic [7:0] m);
    src_valid[i]        = 1'b1;
    src_addr[i*3 +: 3]  = a;
    src_data[i*64 +: 64] = d;
    src_mask[i*8 +: 8]  = m;
  endtask

  task automatic do_reset();
    src_valid = 6'b000000;
    src_addr  = '0;
    src_data  = '0;
    src_mask  = '0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    src_valid = 6'b000000;
    rst_n = 1'b0;
    #2;
    checks++; if (wport_en !== 4'b0000) begin errors++; $display("FAIL reset_en got=%b exp=0000", wport_en); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL reset_busy got=%h exp=00", busy); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (src_ready !== 6'h3F) begin errors++; $display("FAIL reset_ready got=%h exp=3f", src_ready); end
    checks++; if (wport_addr !== 12'h000 || wport_mask !== 32'h0) begin errors++; $display("FAIL reset_addr_mask got=%h/%h exp=0/0", wport_addr, wport_mask); end
    checks++; if (wport_data !== 256'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", wport_data); end
  endtask

  task automatic test_single_write();
    do_reset();
    drive_src(0, 3'd3, 64'h1122334455667788, 8'hFF);
    tick();
    src_valid = 6'b000000;
    checks++; if (busy !== 8'h08) begin errors++; $display("FAIL single_busy_queued got=%h exp=08", busy); end
    checks++; if (wport_en !== 4'b0000) begin errors++; $display("FAIL single_en_early got=%b exp=0000", wport_en); end
    tick();
    checks++; if (wport_en !== 4'b0001) begin errors++; $display("FAIL single_en got=%b exp=0001", wport_en); end
    checks++; if (wport_addr[2:0] !== 3'd3) begin errors++; $display("FAIL single_addr got=%0d exp=3", wport_addr[2:0]); end
    checks++; if (wport_data[63:0] !== 64'h1122334455667788) begin errors++; $display("FAIL single_data got=%h exp=1122334455667788", wport_data[63:0]); end
    checks++; if (wport_mask[7:0] !== 8'hFF) begin errors++; $display("FAIL single_mask got=%h exp=ff", wport_mask[7:0]); end
    checks++; if (busy !== 8'h08) begin errors++; $display("FAIL single_busy_port got=%h exp=08", busy); end
    tick();
    checks++; if (wport_en !== 4'b0000 || busy !== 8'h00) begin errors++; $display("FAIL single_retire got en=%b busy=%h exp 0000/00", wport_en, busy); end
    checks++; if (wport_addr[2:0] !== 3'd3) begin errors++; $display("FAIL single_hold got=%0d exp=3", wport_addr[2:0]); end
  endtask

  task automatic test_conflict();
    do_reset();
    drive_src(1, 3'd5, 64'hAAAA_0000_0000_0001, 8'h0F);
    drive_src(4, 3'd5, 64'hBBBB_0000_0000_0004, 8'hF0);
    tick();
    src_valid = 6'b000000;
    tick();
    checks++; if (wport_en !== 4'b0001 || wport_data[63:0] !== 64'hAAAA_0000_0000_0001) begin errors++; $display("FAIL conflict_first got en=%b data=%h exp 0001/aaaa000000000001", wport_en, wport_data[63:0]); end
    checks++; if (wport_addr[2:0] !== 3'd5) begin errors++; $display("FAIL conflict_addr1 got=%0d exp=5", wport_addr[2:0]); end
    tick();
    checks++; if (wport_en !== 4'b0001 || wport_data[63:0] !== 64'hBBBB_0000_0000_0004) begin errors++; $display("FAIL conflict_second got en=%b data=%h exp 0001/bbbb000000000004", wport_en, wport_data[63:0]); end
    checks++; if (wport_mask[7:0] !== 8'hF0) begin errors++; $display("FAIL conflict_mask2 got=%h exp=f0", wport_mask[7:0]); end
    tick();
    checks++; if (wport_en !== 4'b0000 || busy !== 8'h00) begin errors++; $display("FAIL conflict_drain got en=%b busy=%h exp 0000/00", wport_en, busy); end
`ifdef REGFILE_WR_STATS_EN
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL stats_conflict got=%0d exp=1", stall_cnt); end
`endif
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_src(i, 3'(i), 64'h100 + 64'(i), 8'hFF);
    end
    tick();
    src_valid = 6'b000000;
    tick();
    checks++; if (wport_en !== 4'b1111) begin errors++; $display("FAIL sat_en1 got=%b exp=1111", wport_en); end
    checks++; if (wport_addr !== 12'b011_010_001_000) begin errors++; $display("FAIL sat_addr1 got=%h exp=688", wport_addr); end
    checks++; if (wport_data[255:192] !== 64'h103) begin errors++; $display("FAIL sat_data3 got=%h exp=103", wport_data[255:192]); end
    checks++; if (busy !== 8'h3F) begin errors++; $display("FAIL sat_busy got=%h exp=3f", busy); end
    tick();
    checks++; if (wport_en !== 4'b0011) begin errors++; $display("FAIL sat_en2 got=%b exp=0011", wport_en); end
    checks++; if (wport_addr !== 12'b011_010_101_100) begin errors++; $display("FAIL sat_addr2 got=%h exp=6ac", wport_addr); end
    drive_src(0, 3'd6, 64'h60, 8'h01);
    drive_src(5, 3'd7, 64'h75, 8'h02);
    tick();
    src_valid = 6'b000000;
    tick();
    checks++; if (wport_en !== 4'b0011) begin errors++; $display("FAIL sat_rr_en got=%b exp=0011", wport_en); end
    checks++; if (wport_addr[2:0] !== 3'd6 || wport_addr[5:3] !== 3'd7) begin errors++; $display("FAIL sat_rr_order got p0=%0d p1=%0d exp 6/7", wport_addr[2:0], wport_addr[5:3]); end
  endtask

  task automatic test_mask_zero();
    do_reset();
    drive_src(3, 3'd1, 64'hDEAD_BEEF_0000_0003, 8'h00);
    tick();
    src_valid = 6'b000000;
    tick();
    checks++; if (wport_en !== 4'b0001 || wport_addr[2:0] !== 3'd1) begin errors++; $display("FAIL mask0_write got en=%b addr=%0d exp 0001/1", wport_en, wport_addr[2:0]); end
    checks++; if (wport_mask[7:0] !== 8'h00) begin errors++; $display("FAIL mask0_mask got=%h exp=00", wport_mask[7:0]); end
    tick();
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL mask0_busy got=%h exp=00", busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_src(0, 3'd2, 64'hA0, 8'hFF);
    drive_src(5, 3'd7, 64'h57, 8'hFF);
    drive_src(2, 3'd2, 64'hD1, 8'hFF);
    tick();
    checks++; if (src_ready[2] !== 1'b1) begin errors++; $display("FAIL bp_ready_one got=%b exp=1", src_ready[2]); end
    drive_src(2, 3'd2, 64'hD2, 8'hFF);
    tick();
    checks++; if (src_ready[2] !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b exp=0", src_ready[2]); end
    checks++; if (wport_en !== 4'b0011 || wport_data[63:0] !== 64'hA0 || wport_addr[5:3] !== 3'd7) begin errors++; $display("FAIL bp_blocked1 got en=%b d0=%h a1=%0d exp 0011/a0/7", wport_en, wport_data[63:0], wport_addr[5:3]); end
    drive_src(2, 3'd2, 64'hD3, 8'hFF);
    tick();
    checks++; if (src_ready[2] !== 1'b0 || wport_data[63:0] !== 64'hA0) begin errors++; $display("FAIL bp_blocked2 got rdy=%b d0=%h exp 0/a0", src_ready[2], wport_data[63:0]); end
    src_valid[0] = 1'b0;
    src_valid[5] = 1'b0;
    tick();
    checks++; if (src_ready[2] !== 1'b0 || wport_en !== 4'b0011) begin errors++; $display("FAIL bp_blocked3 got rdy=%b en=%b exp 0/0011", src_ready[2], wport_en); end
    tick();
    checks++; if (wport_en !== 4'b0001 || wport_data[63:0] !== 64'hD1) begin errors++; $display("FAIL bp_d1 got en=%b d0=%h exp 0001/d1", wport_en, wport_data[63:0]); end
    checks++; if (src_ready[2] !== 1'b1) begin errors++; $display("FAIL bp_ready_freed got=%b exp=1", src_ready[2]); end
    tick();
    src_valid = 6'b000000;
    checks++; if (wport_en !== 4'b0001 || wport_data[63:0] !== 64'hD2) begin errors++; $display("FAIL bp_d2 got en=%b d0=%h exp 0001/d2", wport_en, wport_data[63:0]); end
    tick();
    checks++; if (wport_en !== 4'b0001 || wport_data[63:0] !== 64'hD3) begin errors++; $display("FAIL bp_d3 got en=%b d0=%h exp 0001/d3", wport_en, wport_data[63:0]); end
    tick();
    checks++; if (wport_en !== 4'b0000 || busy !== 8'h00) begin errors++; $display("FAIL bp_drain got en=%b busy=%h exp 0000/00", wport_en, busy); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_src(i, 3'd6, 64'hC0 + 64'(i), 8'hFF);
    end
    tick();
    src_valid = 6'b000000;
    tick();
    checks++; if (wport_en !== 4'b0001 || busy !== 8'h40) begin errors++; $display("FAIL midrst_pre got en=%b busy=%h exp 0001/40", wport_en, busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wport_en !== 4'b0000) begin errors++; $display("FAIL midrst_en got=%b exp=0000", wport_en); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL midrst_busy got=%h exp=00", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (wport_en !== 4'b0000 || busy !== 8'h00) begin errors++; $display("FAIL midrst_stale cyc=%0d got en=%b busy=%h exp 0000/00", c, wport_en, busy); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b1;
    src_valid = 6'b000000;
    src_addr  = '0;
    src_data  = '0;
    src_mask  = '0;
    test_reset();
    test_single_write();
    test_conflict();
    test_saturation();
    test_mask_zero();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
